// File: rtl/ifetch_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ifetch_prefetch_queue
//  Purpose  : Sequential instruction prefetch FIFO between the core fetch port
//             and the memory instruction bus. At most one memory request is
//             outstanding; a non-sequential core address flushes the queue and
//             re-targets prefetching.
//  Options  : IFETCH_BYPASS_EN - forward memory data straight to a waiting
//             core when the queue is empty (saves one cycle on a cold miss).
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        creq_valid,
   input  logic [63:0] creq_addr,
   output logic        cresp_data_ok,
   output logic [31:0] cresp_data,
   output logic        mreq_valid,
   output logic [63:0] mreq_addr,
   input  logic        mresp_data_ok,
   input  logic [31:0] mresp_data
);

   localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   localparam logic [1:0] C_ST_IDLE  = 2'd0;
   localparam logic [1:0] C_ST_FETCH = 2'd1;
   localparam logic [1:0] C_ST_STALE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [63:0]      pf_addr_q, pf_addr_d;
   logic [63:0]      fetch_addr_q, fetch_addr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

   logic [63:0]      fifo_addr_q [DEPTH];
   logic [31:0]      fifo_data_q [DEPTH];

   logic        w_not_empty;
   logic [63:0] w_head_addr;
   logic [31:0] w_head_data;
   logic [63:0] w_exp_addr;
   logic        w_hit;
   logic        w_redirect;
   logic        w_mresp_fetch;
   logic        w_bypass;
   logic        w_push;
   logic        w_issue;

   assign w_not_empty   = (count_q != '0);
   assign w_head_addr   = fifo_addr_q[rd_ptr_q];
   assign w_head_data   = fifo_data_q[rd_ptr_q];
   assign w_mresp_fetch = (state_q == C_ST_FETCH) && mresp_data_ok;

   // Address the core is expected to ask for next if the stream is sequential
   always_comb begin
      if (w_not_empty)
         w_exp_addr = w_head_addr;
      else if (state_q == C_ST_FETCH)
         w_exp_addr = fetch_addr_q;
      else
         w_exp_addr = pf_addr_q;
   end

   assign w_hit      = creq_valid && w_not_empty && (w_head_addr == creq_addr);
   assign w_redirect = creq_valid && (w_exp_addr != creq_addr);

`ifdef IFETCH_BYPASS_EN
   assign w_bypass = creq_valid && !w_not_empty && w_mresp_fetch &&
                     (creq_addr == fetch_addr_q);
`else
   assign w_bypass = 1'b0;
`endif

   // A redirect in the same cycle as returning data discards that data
   assign w_push  = w_mresp_fetch && !w_redirect && !w_bypass;
   assign w_issue = (state_q == C_ST_IDLE) && (count_q < C_DEPTH) && !w_redirect;

   assign cresp_data_ok = w_hit || w_bypass;
   assign cresp_data    = w_bypass ? mresp_data : (w_hit ? w_head_data : 32'd0);
   assign mreq_valid    = (state_q != C_ST_IDLE);
   assign mreq_addr     = fetch_addr_q;

   // Next-state for the memory FSM, prefetch address and FIFO bookkeeping
   always_comb begin
      state_d      = state_q;
      pf_addr_d    = pf_addr_q;
      fetch_addr_d = fetch_addr_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;

      case (state_q)
         C_ST_IDLE: begin
            if (w_issue) begin
               fetch_addr_d = pf_addr_q;
               pf_addr_d    = pf_addr_q + 64'd4;
               state_d      = C_ST_FETCH;
            end
         end
         C_ST_FETCH: begin
            if (mresp_data_ok)
               state_d = C_ST_IDLE;
            else if (w_redirect)
               state_d = C_ST_STALE;
         end
         C_ST_STALE: begin
            if (mresp_data_ok)
               state_d = C_ST_IDLE;
         end
         default: state_d = C_ST_IDLE;
      endcase

      if (w_redirect) begin
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         pf_addr_d = creq_addr;
      end else begin
         if (w_push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (w_hit)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (w_push && !w_hit)
            count_d = count_q + CNT_W'(1);
         else if (!w_push && w_hit)
            count_d = count_q - CNT_W'(1);
      end
   end

   // Control state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= C_ST_IDLE;
         pf_addr_q    <= RESET_PC;
         fetch_addr_q <= 64'd0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         pf_addr_q    <= pf_addr_d;
         fetch_addr_q <= fetch_addr_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
      end
   end

   // FIFO storage; contents are qualified by count so no reset is needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_addr_q[wr_ptr_q] <= fetch_addr_q;
         fifo_data_q[wr_ptr_q] <= mresp_data;
      end
   end

endmodule
`default_nettype wire
